// File: rtl/cpu_pkg.sv
// Shared definitions for the minimal program-counter CPU: default sizes,
// opcode encoding and the default program image.
package cpu_pkg;

    localparam int WIDTH_DEFAULT         = 8;
    localparam int COUNTER_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_JMP  = 2'b01,
        OP_HALT = 2'b10,
        OP_SRST = 2'b11
    } opcode_e;

    // Packed program image; element 0 is the rightmost word of the concatenation.
    localparam logic [(2**COUNTER_WIDTH_DEFAULT)-1:0][WIDTH_DEFAULT-1:0] DEFAULT_PROGRAM = {
        {8{8'h80}},   // 15..8 : HALT
        8'hC0,        // 7     : SRST
        8'h00,        // 6     : NOP
        8'h00,        // 5     : NOP
        8'h00,        // 4     : NOP
        8'h46,        // 3     : JMP 6
        8'h00,        // 2     : NOP
        8'h00,        // 1     : NOP
        8'h00         // 0     : NOP
    };

endpackage

// File: rtl/cpu_counter.sv
// Program counter register: the only state in the CPU.
module cpu_counter
    import cpu_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     load,
    input  logic                     hold,
    input  logic                     clear,
    input  logic [COUNTER_WIDTH-1:0] load_value,
    output logic [COUNTER_WIDTH-1:0] count
);

    logic [COUNTER_WIDTH-1:0] count_r;

    // External reset wins over every control; increment wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (hold) begin
            count_r <= count_r;
        end else if (inc) begin
            count_r <= count_r + COUNTER_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: turns the opcode and immediate field
// into one-hot control strobes for the program counter.
module cpu_decoder
    import cpu_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic [1:0]               opcode,
    input  logic [COUNTER_WIDTH-1:0] immediate,
    output logic                     inc,
    output logic                     load,
    output logic                     hold,
    output logic                     clear,
    output logic [COUNTER_WIDTH-1:0] load_value
);

    opcode_e op_s;

    // Map each opcode onto exactly one counter control; a JMP to its own
    // address is just a load of the current value and therefore holds.
    always_comb begin
        op_s       = opcode_e'(opcode);
        inc        = 1'b0;
        load       = 1'b0;
        hold       = 1'b0;
        clear      = 1'b0;
        load_value = immediate;
        case (op_s)
            OP_NOP:  inc   = 1'b1;
            OP_JMP:  load  = 1'b1;
            OP_HALT: hold  = 1'b1;
            OP_SRST: clear = 1'b1;
            default: clear = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Minimal CPU: a program counter stepping through a constant program ROM,
// one instruction per clock, with NOP / JMP / HALT / soft-reset opcodes.
module cpu
    import cpu_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT,
    parameter logic [(2**COUNTER_WIDTH)-1:0][WIDTH-1:0] PROGRAM = DEFAULT_PROGRAM
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic [WIDTH-1:0]         instruction
);

    logic                     inc_s;
    logic                     load_s;
    logic                     hold_s;
    logic                     clear_s;
    logic [COUNTER_WIDTH-1:0] load_value_s;

    // Program fetch is a pure ROM lookup with no latency.
    assign instruction = PROGRAM[count];

    cpu_decoder #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_decoder (
        .opcode     (instruction[WIDTH-1 -: 2]),
        .immediate  (instruction[COUNTER_WIDTH-1:0]),
        .inc        (inc_s),
        .load       (load_s),
        .hold       (hold_s),
        .clear      (clear_s),
        .load_value (load_value_s)
    );

    cpu_counter #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .inc        (inc_s),
        .load       (load_s),
        .hold       (hold_s),
        .clear      (clear_s),
        .load_value (load_value_s),
        .count      (count)
    );

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: four instances with different programs run
// side by side; the stimulus pushes the expected post-edge state into one
// queue per instance and a negedge monitor pops and compares.
module tb_cpu;

    typedef struct packed {
        logic [3:0] cnt;
        logic [7:0] ins;
    } exp_t;

    localparam int NCYC = 20;

    // Bench-owned program images (index 0 is rightmost).
    localparam logic [15:0][7:0] PROG_DEF  = {{8{8'h80}}, 8'hC0, 8'h00, 8'h00, 8'h00,
                                              8'h46, 8'h00, 8'h00, 8'h00};
    localparam logic [15:0][7:0] PROG_HALT = {{13{8'h00}}, 8'h8A, 8'h00, 8'h00};
    localparam logic [15:0][7:0] PROG_NOP  = {16{8'h00}};
    localparam logic [15:0][7:0] PROG_JMP  = {{10{8'h00}}, 8'h45, {5{8'h00}}};

    // Reset patterns: A/B get a mid-program reset on cycle 11.
    logic rst_ab_tbl [NCYC] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic rst_cd_tbl [NCYC] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Hand-computed count after each edge.
    logic [3:0] cnt_a_tbl [NCYC] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2,
                                     4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2};
    logic [3:0] cnt_b_tbl [NCYC] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
                                     4'd2, 4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] cnt_c_tbl [NCYC] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                     4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    logic [3:0] cnt_d_tbl [NCYC] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5,
                                     4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};

    logic       clock;
    logic       rst_a, rst_b, rst_c, rst_d;
    logic [3:0] count_a, count_b, count_c, count_d;
    logic [7:0] instr_a, instr_b, instr_c, instr_d;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t qd[$];

    int tests  = 0;
    int failed = 0;

    cpu u_a (.clock(clock), .reset(rst_a), .count(count_a), .instruction(instr_a));
    cpu #(.PROGRAM(PROG_HALT)) u_b (.clock(clock), .reset(rst_b), .count(count_b), .instruction(instr_b));
    cpu #(.PROGRAM(PROG_NOP))  u_c (.clock(clock), .reset(rst_c), .count(count_c), .instruction(instr_c));
    cpu #(.PROGRAM(PROG_JMP))  u_d (.clock(clock), .reset(rst_d), .count(count_d), .instruction(instr_d));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [3:0] ac, input logic [7:0] ai, input exp_t e);
        tests++;
        if (ac !== e.cnt) begin
            failed++;
            $display("FAIL %s count: got %0d expected %0d at %0t", name, ac, e.cnt, $time);
        end
        tests++;
        if (ai !== e.ins) begin
            failed++;
            $display("FAIL %s instruction: got %h expected %h at %0t", name, ai, e.ins, $time);
        end
    endtask

    // Monitor: every negedge, compare each instance against its queue head.
    always @(negedge clock) begin
        if (qa.size() > 0) chk("default_prog", count_a, instr_a, qa.pop_front());
        if (qb.size() > 0) chk("halt_prog", count_b, instr_b, qb.pop_front());
        if (qc.size() > 0) chk("nop_wrap", count_c, instr_c, qc.pop_front());
        if (qd.size() > 0) chk("jmp_self", count_d, instr_d, qd.pop_front());
    end

    // Stimulus: drive resets, let the edge happen, push the expected state.
    initial begin
        exp_t e;
        for (int k = 0; k < NCYC; k++) begin
            rst_a = rst_ab_tbl[k];
            rst_b = rst_ab_tbl[k];
            rst_c = rst_cd_tbl[k];
            rst_d = rst_cd_tbl[k];
            @(posedge clock);
            #1;
            e.cnt = cnt_a_tbl[k]; e.ins = PROG_DEF[cnt_a_tbl[k]];  qa.push_back(e);
            e.cnt = cnt_b_tbl[k]; e.ins = PROG_HALT[cnt_b_tbl[k]]; qb.push_back(e);
            e.cnt = cnt_c_tbl[k]; e.ins = PROG_NOP[cnt_c_tbl[k]];  qc.push_back(e);
            e.cnt = cnt_d_tbl[k]; e.ins = PROG_JMP[cnt_d_tbl[k]];  qd.push_back(e);
        end
        @(negedge clock);
        @(negedge clock);
        tests++;
        if ((qa.size() + qb.size() + qc.size() + qd.size()) != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0",
                     qa.size() + qb.size() + qc.size() + qd.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
